// File: rtl/fetch_unit.sv
// fetch_unit -- three-cycle instruction fetch stage with a valid/ready
// handshake towards decode, branch redirect and a halt request.
//
// Ports:
//   clk           sole clock, all state changes on its rising edge
//   rst           synchronous active-high reset
//   mem_addr      word address to instruction RAM (equals pc)
//   mem_we        RAM write enable, tied low
//   mem_datain    RAM write data, tied to zero
//   mem_rdata     RAM read data, refreshed by the RAM on the falling edge
//   instr         fetched instruction word
//   instr_pc      address instr was fetched from
//   instr_valid   instr / instr_pc hold a valid instruction
//   instr_ready   decode accepts the instruction this cycle
//   branch_valid  one-cycle redirect request
//   branch_target redirect address
//   halt          level request to stop fetching
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_datain,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  input  logic        halt
);

  localparam logic [1:0] S_ADDR = 2'd0;  // address presented, RAM reads on negedge
  localparam logic [1:0] S_CAPT = 2'd1;  // RAM data stable, latch it
  localparam logic [1:0] S_HOLD = 2'd2;  // instruction offered to decode
  localparam logic [1:0] S_HALT = 2'd3;  // fetching stopped

  logic [1:0]  state;
  logic [15:0] pc;

  assign mem_addr   = pc;
  assign mem_we     = 1'b0;
  assign mem_datain = 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= S_ADDR;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
    end else if (branch_valid) begin
      pc <= branch_target;
      // While halted a redirect only moves pc; the halt level alone
      // decides when fetching resumes.
      if (state != S_HALT) begin
        instr_valid <= 1'b0;
        state       <= S_ADDR;
      end
    end else begin
      case (state)
        S_ADDR: state <= S_CAPT;
        S_CAPT: begin
          instr       <= mem_rdata;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + 16'd1;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            // Halt is only honoured at the point a new fetch would begin.
            state       <= halt ? S_HALT : S_ADDR;
          end
        end
        default: begin
          if (!halt) begin
            state <= S_ADDR;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed scenarios plus randomized stimulus for fetch_unit,
// checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_datain;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        branch_valid = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        halt = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:65535];

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_datain(mem_datain), .mem_rdata(mem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target), .halt(halt)
  );

  always #5 clk = ~clk;

  // RAM: read data refreshed on the falling edge
  always @(negedge clk) mem_rdata <= mem[mem_addr];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: counts posedges until the next capture instead of
  // tracking a state encoding.
  logic [15:0] m_pc, m_instr, m_ipc;
  logic        m_valid, m_halted;
  int          m_cnt;
  bit          started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
      m_valid = 0; m_halted = 0; m_cnt = 2; started = 1;
    end else if (started) begin
      if (m_halted) begin
        if (branch_valid) m_pc = branch_target;
        else if (!halt) begin m_halted = 0; m_cnt = 2; end
      end else if (branch_valid) begin
        m_pc = branch_target; m_valid = 0; m_cnt = 2;
      end else if (m_valid) begin
        if (instr_ready) begin
          m_valid = 0;
          if (halt) m_halted = 1; else m_cnt = 2;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_instr = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 16'd1; m_valid = 1;
        end
      end
    end
    #1;
    if (started) begin
      check("model_valid", {15'd0, instr_valid}, {15'd0, m_valid});
      check("model_addr", mem_addr, m_pc);
      check("model_instr", instr, m_instr);
      check("model_ipc", instr_pc, m_ipc);
      check("model_we", {15'd0, mem_we}, 16'd0);
      check("model_wdata", mem_datain, 16'h0000);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Reset held across two edges, released at a negedge
  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h80FE; mem[1] = 16'h89ED; mem[2] = 16'h2220; mem[6] = 16'hC005;

    // basic stream with ready high
    cyc(2);
    check("rst_valid", {15'd0, instr_valid}, 16'd0);
    check("rst_instr", instr, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    rst = 1'b0;
    cyc(1); check("first_not_yet", {15'd0, instr_valid}, 16'd0);
    cyc(1); check("i0_valid", {15'd0, instr_valid}, 16'd1);
    check("i0_instr", instr, 16'h80FE); check("i0_pc", instr_pc, 16'h0000);
    cyc(3); check("i1_instr", instr, 16'h89ED); check("i1_pc", instr_pc, 16'h0001);
    cyc(3); check("i2_instr", instr, 16'h2220); check("i2_pc", instr_pc, 16'h0002);

    // backpressure
    instr_ready = 1'b0; do_reset(); cyc(2);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("bp_valid", {15'd0, instr_valid}, 16'd1);
      check("bp_instr", instr, 16'h80FE); check("bp_addr", mem_addr, 16'h0001);
    end
    instr_ready = 1'b1;
    cyc(1); check("bp_drop", {15'd0, instr_valid}, 16'd0);
    cyc(3); check("bp_next", instr, 16'h89ED);

    // branch while holding
    instr_ready = 1'b0; do_reset(); cyc(2);
    branch_valid = 1'b1; branch_target = 16'h0006;
    cyc(1); branch_valid = 1'b0;
    check("br_kill", {15'd0, instr_valid}, 16'd0); check("br_addr", mem_addr, 16'h0006);
    cyc(2); check("br_instr", instr, 16'hC005); check("br_pc", instr_pc, 16'h0006);

    // branch to the top of memory, pc wraps
    do_reset(); cyc(2);
    branch_valid = 1'b1; branch_target = 16'hFFFF;
    cyc(1); branch_valid = 1'b0;
    cyc(2); check("wrap_pc", instr_pc, 16'hFFFF); check("wrap_addr", mem_addr, 16'h0000);
    instr_ready = 1'b1;
    cyc(4); check("wrap_next_pc", instr_pc, 16'h0000); check("wrap_next", instr, 16'h80FE);

    // halt: held instruction survives, then fetch stops, then resumes
    instr_ready = 1'b0; halt = 1'b1; do_reset(); cyc(2);
    cyc(2); check("halt_hold", instr, 16'h80FE); check("halt_hold_v", {15'd0, instr_valid}, 16'd1);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("halt_v", {15'd0, instr_valid}, 16'd0); check("halt_addr", mem_addr, 16'h0001);
    end
    halt = 1'b0;
    cyc(3); check("resume_instr", instr, 16'h89ED); check("resume_pc", instr_pc, 16'h0001);

    // reset while holding
    instr_ready = 1'b0; do_reset(); cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("rst_hold_v", {15'd0, instr_valid}, 16'd0); check("rst_hold_addr", mem_addr, 16'h0000);
    cyc(2); check("rst_restart", instr, 16'h80FE);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      instr_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      branch_valid = ($urandom_range(0, 9) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                  : 16'($urandom);
      // A redirect in the same cycle that halt releases is left untested.
      if (m_halted && !halt) branch_valid = 1'b0;
      cyc(1);
    end
    rst = 1'b0; branch_valid = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
